screen_sequencer: RTL
=====================

// Module: screen_sequencer
// PURPOSE
//  Downstream stage of the per-screen pixel generators. Selects game-screen or switch-player
//  wait-screen RGB, registers the pixel, and delays hsync/vsync/vde to match font-ROM latency.
//  Runs the turn-hand-off FSM: screen changes only at frame start, so no tearing.
//  Enforces a minimum wait-screen time and advances the active player.
// PARAMETERS
//  NUM_PLAYERS      2   players in rotation; active_player wraps modulo this
//  MIN_WAIT_FRAMES  30  frames the wait screen must show before continue is accepted
//  SYNC_DELAY       2   clk cycles from hsync/vsync/vde in to out (font ROM 1 + output reg 1); >=1
// PORTS
//  clk            in   1   pixel clock
//  reset_n        in   1   synchronous, active-low reset
//  hsync_in       in   1   active-low horizontal sync from VGA controller
//  vsync_in       in   1   active-low vertical sync from VGA controller
//  vde_in         in   1   video data enable (DrawX/DrawY in visible area)
//  turn_done      in   1   one-cycle pulse from game logic: current player ended turn
//  continue_btn   in   1   asynchronous level from push button, active-high
//  game_rgb       in   12  {R,G,B} from game screen, valid SYNC_DELAY-1 cycles after syncs
//  wait_rgb       in   12  {R,G,B} from wait screen, same alignment as game_rgb
//  Red/Green/Blue out  4   registered pixel to VGA/HDMI encoder
//  hsync_out      out  1   hsync_in delayed SYNC_DELAY cycles
//  vsync_out      out  1   vsync_in delayed SYNC_DELAY cycles
//  vde_out        out  1   vde_in delayed SYNC_DELAY cycles
//  wait_active    out  1   1 while wait RGB is selected
//  active_player  out  $clog2(NUM_PLAYERS)  index of player whose turn it is
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state GAME, active_player=0, frame_cnt=0, RGB=0,
//   hsync_out=vsync_out=1, vde_out=0, delay-line stages =1/1/0, button sync flops =0.
//  frame_start: registered vsync_in 1 and current vsync_in 0 (falling edge). Single-cycle.
//  continue_btn: 2-FF synchronizer, then rising-edge detect -> cont_pulse (3rd cycle after edge).
//  FSM states:
//   GAME       : turn_done -> WAIT_ARM. cont_pulse ignored.
//   WAIT_ARM   : frame_start -> WAIT, frame_cnt<=0. turn_done ignored.
//   WAIT       : frame_start -> frame_cnt++ saturating at MIN_WAIT_FRAMES.
//                cont_pulse with (pre-update) frame_cnt==MIN_WAIT_FRAMES -> RESUME_ARM,
//                active_player <= (p+1==NUM_PLAYERS)?0:p+1 in same cycle. Early press dropped.
//   RESUME_ARM : frame_start -> GAME. Further cont_pulse/turn_done ignored.
//  turn_done and frame_start in the same cycle in GAME: go to WAIT_ARM only. That frame_start
//   is not consumed, so the wait screen starts at the next frame.
//  wait_active = state in {WAIT, RESUME_ARM}. Select changes only on a frame_start edge.
//  Pixel: vde_al = vde_in delayed SYNC_DELAY-1 (0 -> vde_in itself).
//   Next RGB = vde_al ? (wait_active ? wait_rgb : game_rgb) : 12'h000.
//   One register, so RGB and syncs exit aligned.
//  Sync/vde paths: pure shift registers. Never gated by FSM state.
//  Reset mid-frame: outputs forced to reset values next edge; FSM resumes in GAME, player 0.
// STRUCTURE
//  screen_pkg: typedef enum logic [1:0] {GAME, WAIT_ARM, WAIT, RESUME_ARM} screen_state_t;
//   localparam RGB_BLACK = 12'h000.
//  Sub-module sync_delay_line #(WIDTH, DEPTH, RESET_VAL):
//   synchronous active-low reset shift register, used for {hsync,vsync,vde}.
//  FSM, button sync/edge, frame counter and output register live in screen_sequencer.
// TESTING (synthetic 32x8 frame timing; MIN_WAIT_FRAMES=3, NUM_PLAYERS=2, SYNC_DELAY=2)
//  1 Reset held 4 cycles, syncs toggling -> RGB=0, hsync_out=vsync_out=1, vde_out=0,
//    wait_active=0, player=0. After release, vsync_out equals vsync_in 2 cycles earlier.
//  2 turn_done mid-frame, game_rgb=12'h362, wait_rgb=12'heec -> output stays 362 to frame end.
//    First visible pixel after next frame_start is eec; wait_active rises in the frame_start cycle.
//  3 In WAIT, press continue after 1 frame -> ignored, player=0.
//    Press after 3 frames -> player=1, screen returns to game at next frame_start.
//  4 Two full hand-offs -> active_player sequence 0,1,0 (wrap).
//  5 turn_done coincident with frame_start -> WAIT entered at the following frame_start, not this one.
//  6 vde_in low (blanking) while wait_active -> RGB=000. reset_n low during WAIT -> GAME, player 0.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types for the screen sequencer: hand-off FSM states and the blanking colour.
// Pure declarations; no logic, no latency.
package screen_pkg;
    typedef enum logic [1:0] {GAME, WAIT_ARM, WAIT, RESUME_ARM} screen_state_t;
    localparam logic [11:0] RGB_BLACK = 12'h000;
endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a synchronous active-low reset to RESET_VAL.
// Latency DEPTH cycles; free-running, no backpressure.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign dout = r_stage[DEPTH-1];
endmodule

// File: rtl/screen_sequencer.sv
// Picks game or wait-screen RGB, registers it aligned with delayed syncs, and runs the turn hand-off FSM.
// Latency SYNC_DELAY cycles for syncs/pixel; free-running, no backpressure.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int  NUM_PLAYERS     = 2,
    parameter int  MIN_WAIT_FRAMES = 30,
    parameter int  SYNC_DELAY      = 2,
    localparam int PW              = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          vde_in,
    input  logic          turn_done,
    input  logic          continue_btn,
    input  logic [11:0]   game_rgb,
    input  logic [11:0]   wait_rgb,
    output logic [3:0]    Red,
    output logic [3:0]    Green,
    output logic [3:0]    Blue,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          vde_out,
    output logic          wait_active,
    output logic [PW-1:0] active_player
);
    localparam int             CW      = $clog2(MIN_WAIT_FRAMES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MIN_WAIT_FRAMES);

    screen_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_frame_cnt, w_cnt_nxt;
    logic [PW-1:0] r_player, w_player_nxt, w_player_inc;
    logic          r_vsync_d;
    logic          r_btn_meta, r_btn_sync, r_btn_prev;
    logic [11:0]   r_rgb;
    logic          w_frame_start, w_cont_pulse, w_vde_al;
    logic [2:0]    w_sync_out;

    sync_delay_line #(.WIDTH(3), .DEPTH(SYNC_DELAY), .RESET_VAL(3'b110)) u_sync_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({hsync_in, vsync_in, vde_in}),
        .dout    (w_sync_out)
    );
    assign {hsync_out, vsync_out, vde_out} = w_sync_out;

    // The pixel register is the last stage, so vde is pre-aligned one cycle short.
    generate
        if (SYNC_DELAY > 1) begin : g_vde_al
            sync_delay_line #(.WIDTH(1), .DEPTH(SYNC_DELAY-1), .RESET_VAL(1'b0)) u_vde_dly (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (vde_in),
                .dout    (w_vde_al)
            );
        end else begin : g_vde_direct
            assign w_vde_al = vde_in;
        end
    endgenerate

    assign w_frame_start = r_vsync_d & ~vsync_in;
    assign w_cont_pulse  = r_btn_sync & ~r_btn_prev;
    assign w_player_inc  = (int'(r_player) == NUM_PLAYERS - 1) ? '0 : r_player + 1'b1;
    assign wait_active   = (r_state == WAIT) || (r_state == RESUME_ARM);
    assign active_player = r_player;
    assign {Red, Green, Blue} = r_rgb;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= GAME;
            r_frame_cnt <= '0;
            r_player    <= '0;
            r_vsync_d   <= 1'b1;
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_btn_prev  <= 1'b0;
            r_rgb       <= RGB_BLACK;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_player    <= w_player_nxt;
            r_vsync_d   <= vsync_in;
            r_btn_meta  <= continue_btn;
            r_btn_sync  <= r_btn_meta;
            r_btn_prev  <= r_btn_sync;
            r_rgb       <= w_vde_al ? (wait_active ? wait_rgb : game_rgb) : RGB_BLACK;
        end
    end

    // Screen only flips on frame_start; a turn_done on that same cycle waits a frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_frame_cnt;
        w_player_nxt = r_player;
        case (r_state)
            GAME: begin
                if (turn_done) w_state_nxt = WAIT_ARM;
            end
            WAIT_ARM: begin
                if (w_frame_start) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (w_frame_start && (r_frame_cnt != CNT_MAX)) w_cnt_nxt = r_frame_cnt + 1'b1;
                if (w_cont_pulse && (r_frame_cnt == CNT_MAX)) begin
                    w_state_nxt  = RESUME_ARM;
                    w_player_nxt = w_player_inc;
                end
            end
            RESUME_ARM: begin
                if (w_frame_start) w_state_nxt = GAME;
            end
            default: w_state_nxt = GAME;
        endcase
    end
endmodule
